// File: rtl/uart_baud_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : uart_baud_ctrl                                                |
// | Brief    : UART baud timing: oversampling divisor, TX bit strobes and    |
// |            RX mid-bit sample strobes, with runtime divisor reload.       |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module uart_baud_ctrl #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 9600,
  parameter int OSR      = 16,
  parameter int DIV_W    = 16,
  parameter int DEF_DIV  = CLK_FREQ / (BAUD * OSR)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_wr,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             cfg_busy,
  output logic             cfg_err,
  output logic [DIV_W-1:0] cur_div,
  input  logic             tx_en,
  input  logic             rx_start,
  input  logic             rx_stop,
  output logic             os_tick,
  output logic             tx_bit_tick,
  output logic             rx_sample,
  output logic             rx_active
);

  localparam int                c_os_w    = (OSR > 1) ? $clog2(OSR) : 1;
  localparam logic [DIV_W-1:0]  c_def_div = DIV_W'(DEF_DIV);
  localparam logic [c_os_w-1:0] c_os_last = c_os_w'(OSR - 1);
  localparam logic [c_os_w-1:0] c_os_mid  = c_os_w'(OSR / 2 - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } rx_state_t;

  logic [DIV_W-1:0]  r_div_cnt;
  logic [DIV_W-1:0]  r_cur_div;
  logic [DIV_W-1:0]  r_pending;
  logic              r_busy;
  logic              r_err;
  logic              r_os_tick;
  logic [c_os_w-1:0] r_tx_os;
  logic [c_os_w-1:0] r_rx_os;
  rx_state_t         r_rx_state;

  logic [DIV_W-1:0]  w_div_cnt_nxt;
  logic [DIV_W-1:0]  w_cur_div_nxt;
  logic              w_wr_ok;
  logic              w_wr_bad;
  rx_state_t         w_rx_state_nxt;
  logic [c_os_w-1:0] w_rx_os_nxt;
  logic              w_rx_sample;
  logic              w_rx_active;

  // A pending divisor only takes over at a period boundary, so no period is cut short.
  always_comb begin
    w_wr_ok       = cfg_wr && !r_busy && (cfg_div >= DIV_W'(2));
    w_wr_bad      = cfg_wr && !r_busy && (cfg_div <  DIV_W'(2));
    w_div_cnt_nxt = r_os_tick ? '0 : r_div_cnt + DIV_W'(1);
    w_cur_div_nxt = (r_os_tick && r_busy) ? r_pending : r_cur_div;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_div_cnt <= '0;
      r_cur_div <= c_def_div;
      r_pending <= '0;
      r_busy    <= 1'b0;
      r_err     <= 1'b0;
      r_os_tick <= 1'b0;
    end else begin
      r_div_cnt <= w_div_cnt_nxt;
      r_cur_div <= w_cur_div_nxt;
      r_os_tick <= (w_div_cnt_nxt == w_cur_div_nxt - DIV_W'(1));
      r_err     <= w_wr_bad;
      if (w_wr_ok) begin
        r_pending <= cfg_div;
        r_busy    <= 1'b1;
      end else if (r_os_tick && r_busy) begin
        r_busy    <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_tx_os <= '0;
    end else if (!tx_en) begin
      r_tx_os <= '0;
    end else if (r_os_tick) begin
      r_tx_os <= (r_tx_os == c_os_last) ? '0 : r_tx_os + c_os_w'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rx_state <= S_IDLE;
      r_rx_os    <= '0;
    end else begin
      r_rx_state <= w_rx_state_nxt;
      r_rx_os    <= w_rx_os_nxt;
    end
  end

  // Starting resets the phase so the tick coincident with rx_start is not counted.
  always_comb begin
    w_rx_state_nxt = r_rx_state;
    w_rx_os_nxt    = r_rx_os;
    w_rx_sample    = 1'b0;
    w_rx_active    = 1'b0;
    case (r_rx_state)
      S_IDLE: begin
        if (rx_start) begin
          w_rx_state_nxt = S_RUN;
          w_rx_os_nxt    = '0;
        end
      end
      S_RUN: begin
        w_rx_active = 1'b1;
        w_rx_sample = r_os_tick && (r_rx_os == c_os_mid);
        if (rx_stop) begin
          w_rx_state_nxt = S_IDLE;
          w_rx_os_nxt    = '0;
        end else if (r_os_tick) begin
          w_rx_os_nxt = (r_rx_os == c_os_last) ? '0 : r_rx_os + c_os_w'(1);
        end
      end
      default: begin
        w_rx_state_nxt = S_IDLE;
        w_rx_os_nxt    = '0;
      end
    endcase
  end

  assign cfg_busy    = r_busy;
  assign cfg_err     = r_err;
  assign cur_div     = r_cur_div;
  assign os_tick     = r_os_tick;
  assign tx_bit_tick = tx_en && r_os_tick && (r_tx_os == c_os_last);
  assign rx_sample   = w_rx_sample;
  assign rx_active   = w_rx_active;

endmodule
`default_nettype wire

// File: tb/tb_uart_baud_ctrl.sv
`default_nettype none
// Testbench for uart_baud_ctrl: table-driven divisor/config vectors plus
// directed TX, RX and reset sequences (DEF_DIV = 10, OSR = 16).
module tb_uart_baud_ctrl;

  localparam int CLK_FREQ = 1_600_000;
  localparam int BAUD     = 10_000;
  localparam int OSR      = 16;
  localparam int DIV_W    = 16;
  localparam int NVEC     = 45;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             cfg_wr = 1'b0;
  logic [DIV_W-1:0] cfg_div = '0;
  logic             tx_en = 1'b0;
  logic             rx_start = 1'b0;
  logic             rx_stop = 1'b0;
  logic             cfg_busy;
  logic             cfg_err;
  logic [DIV_W-1:0] cur_div;
  logic             os_tick;
  logic             tx_bit_tick;
  logic             rx_sample;
  logic             rx_active;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_baud_ctrl #(
    .CLK_FREQ(CLK_FREQ),
    .BAUD    (BAUD),
    .OSR     (OSR),
    .DIV_W   (DIV_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_wr     (cfg_wr),
    .cfg_div    (cfg_div),
    .cfg_busy   (cfg_busy),
    .cfg_err    (cfg_err),
    .cur_div    (cur_div),
    .tx_en      (tx_en),
    .rx_start   (rx_start),
    .rx_stop    (rx_stop),
    .os_tick    (os_tick),
    .tx_bit_tick(tx_bit_tick),
    .rx_sample  (rx_sample),
    .rx_active  (rx_active)
  );

  typedef struct packed {
    logic             wr;
    logic [DIV_W-1:0] div;
    logic             tick;
    logic             busy;
    logic             err;
    logic [DIV_W-1:0] cur;
  } vec_t;

  vec_t vecs [1:NVEC];
  int   tick_at [7];

  int   s_ticks, s_ntx, s_tx_first, s_tx_gap, s_nrx, s_rx_first, s_rx_cyc, s_rx_gap;
  logic s_act0, s_stray;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic align_tick();
    int n = 0;
    while (!os_tick && n < 40) begin
      step();
      n++;
    end
    check("align os_tick", os_tick, 1);
  endtask

  // Runs ncyc cycles; os_tick indices are counted from the first edge of the scan.
  task automatic scan(input int ncyc, input int start_at, input int start2_at, input int stop_at);
    int last_tx = -1;
    int last_rx = -1;
    s_ticks = 0; s_ntx = 0; s_tx_first = -1; s_tx_gap = -1;
    s_nrx = 0; s_rx_first = -1; s_rx_cyc = -1; s_rx_gap = -1;
    s_act0 = 1'b0; s_stray = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      rx_start = (c == start_at) || (c == start2_at);
      rx_stop  = (c == stop_at);
      step();
      rx_start = 1'b0;
      rx_stop  = 1'b0;
      if (c == 0) s_act0 = rx_active;
      if (os_tick) s_ticks++;
      if ((tx_bit_tick || rx_sample) && !os_tick) s_stray = 1'b1;
      if (tx_bit_tick) begin
        s_ntx++;
        if (last_tx < 0) s_tx_first = s_ticks;
        else if (s_tx_gap < 0) s_tx_gap = c - last_tx;
        last_tx = c;
      end
      if (rx_sample) begin
        s_nrx++;
        if (last_rx < 0) begin
          s_rx_first = s_ticks;
          s_rx_cyc   = c;
        end else if (s_rx_gap < 0) begin
          s_rx_gap = c - last_rx;
        end
        last_rx = c;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected summary before it");
    $fatal(1);
  end

  initial begin
    int n;

    // Vector i is applied before edge i after reset release and checked after it.
    tick_at = '{9, 19, 23, 27, 31, 35, 45};
    for (int i = 1; i <= NVEC; i++) begin
      vecs[i].wr   = 1'b0;
      vecs[i].div  = '0;
      vecs[i].tick = 1'b0;
      vecs[i].busy = ((i >= 13) && (i <= 19)) || ((i >= 32) && (i <= 35));
      vecs[i].err  = (i == 25) || (i == 28);
      vecs[i].cur  = ((i >= 20) && (i <= 35)) ? DIV_W'(4) : DIV_W'(10);
    end
    foreach (tick_at[k]) vecs[tick_at[k]].tick = 1'b1;
    vecs[13].wr = 1'b1; vecs[13].div = DIV_W'(4);
    vecs[15].wr = 1'b1; vecs[15].div = DIV_W'(7);
    vecs[25].wr = 1'b1; vecs[25].div = DIV_W'(1);
    vecs[28].wr = 1'b1; vecs[28].div = DIV_W'(0);
    vecs[32].wr = 1'b1; vecs[32].div = DIV_W'(10);

    rst = 1'b0;
    step();
    step();
    check("reset os_tick", os_tick, 0);
    check("reset tx_bit_tick", tx_bit_tick, 0);
    check("reset rx_sample", rx_sample, 0);
    check("reset rx_active", rx_active, 0);
    check("reset cfg_busy", cfg_busy, 0);
    check("reset cfg_err", cfg_err, 0);
    check("reset cur_div", cur_div, 10);
    rst = 1'b1;

    for (int i = 1; i <= NVEC; i++) begin
      cfg_wr  = vecs[i].wr;
      cfg_div = vecs[i].div;
      step();
      cfg_wr  = 1'b0;
      check($sformatf("vec%0d os_tick", i), os_tick, vecs[i].tick);
      check($sformatf("vec%0d cfg_busy", i), cfg_busy, vecs[i].busy);
      check($sformatf("vec%0d cfg_err", i), cfg_err, vecs[i].err);
      check($sformatf("vec%0d cur_div", i), cur_div, vecs[i].cur);
      if (i <= 12) check($sformatf("vec%0d tx_bit_tick", i), tx_bit_tick, 0);
    end

    // TX: raise tx_en one cycle after a tick, expect strobes on ticks 16 and 32.
    align_tick();
    step();
    tx_en = 1'b1;
    scan(330, -1, -1, -1);
    check("tx os_tick count", s_ticks, 33);
    check("tx strobe count", s_ntx, 2);
    check("tx first strobe tick index", s_tx_first, 16);
    check("tx strobe period cycles", s_tx_gap, 160);
    check("tx strobe off-tick", s_stray, 0);

    // One-cycle tx_en drop must restart the count from zero.
    align_tick();
    step();
    tx_en = 1'b0;
    step();
    check("tx_en low no strobe", tx_bit_tick, 0);
    tx_en = 1'b1;
    scan(170, -1, -1, -1);
    check("tx restart strobe count", s_ntx, 1);
    check("tx restart first tick index", s_tx_first, 16);
    tx_en = 1'b0;

    // RX: start coincident with a tick (not counted), a second start mid-run is ignored.
    align_tick();
    scan(400, 0, 120, -1);
    check("rx_active after start", s_act0, 1);
    check("rx first sample tick index", s_rx_first, 8);
    check("rx first sample latency", s_rx_cyc, 79);
    check("rx sample period cycles", s_rx_gap, 160);
    check("rx sample count", s_nrx, 3);
    check("rx sample off-tick", s_stray, 0);

    // Start and stop together while running: stop wins.
    scan(200, 50, -1, 50);
    check("rx stop no sample", s_nrx, 0);
    check("rx stop rx_active", rx_active, 0);

    // Start and stop together while idle: start wins.
    scan(20, 0, -1, 0);
    check("rx idle start+stop active", s_act0, 1);
    check("rx idle start+stop still run", rx_active, 1);

    // Reset mid-operation with RX running, TX enabled and a divisor pending.
    tx_en   = 1'b1;
    cfg_wr  = 1'b1;
    cfg_div = DIV_W'(5);
    step();
    cfg_wr  = 1'b0;
    check("pre-reset cfg_busy", cfg_busy, 1);
    rst = 1'b0;
    step();
    rst = 1'b1;
    check("mid reset os_tick", os_tick, 0);
    check("mid reset tx_bit_tick", tx_bit_tick, 0);
    check("mid reset rx_sample", rx_sample, 0);
    check("mid reset rx_active", rx_active, 0);
    check("mid reset cfg_busy", cfg_busy, 0);
    check("mid reset cur_div", cur_div, 10);
    n = 0;
    do begin
      step();
      n++;
    end while (!os_tick && n < 20);
    check("post reset first tick edge", n, 9);
    step();
    check("post reset cur_div kept", cur_div, 10);
    check("post reset rx_active", rx_active, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
